// File: rtl/system_sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words after a start
// pulse and checks them against build-time values, with per-read timeout and retry.
module system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1395606384,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  error_code,
  output logic [31:0] id_out,
  output logic [31:0] timestamp_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_ID, S_WAIT_ID, S_REQ_TS, S_WAIT_TS, S_CHECK, S_DONE
  } state_t;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  state_t      r_state, w_state_nxt, w_tmo_dst;
  logic [15:0] r_tcnt;
  logic [3:0]  r_retry;
  logic        r_pass;
  logic [1:0]  r_err;
  logic [31:0] r_id, r_ts;
  logic        w_in_rd, w_is_wait, w_tmo, w_retry_ok, w_tcnt_clr;
  logic [1:0]  w_code;

  assign w_in_rd    = (r_state == S_REQ_ID) || (r_state == S_WAIT_ID) ||
                      (r_state == S_REQ_TS) || (r_state == S_WAIT_TS);
  assign w_is_wait  = (r_state == S_WAIT_ID) || (r_state == S_WAIT_TS);
  // A response landing on the last allowed cycle wins over the timeout.
  assign w_tmo      = w_in_rd && (r_tcnt == TMO_LAST) && !(w_is_wait && avm_readdatavalid);
  assign w_retry_ok = r_retry < RETRY_MAX;
  assign w_tmo_dst  = w_retry_ok ? S_REQ_ID : S_DONE;
  assign w_tcnt_clr = ((w_state_nxt == S_REQ_ID) && ((r_state != S_REQ_ID) || w_tmo)) ||
                      ((w_state_nxt == S_REQ_TS) && (r_state != S_REQ_TS));
  assign w_code     = (r_id != EXPECTED_ID)        ? 2'd1 :
                      (r_ts != EXPECTED_TIMESTAMP) ? 2'd2 : 2'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_REQ_ID;
      S_REQ_ID:  if (w_tmo) w_state_nxt = w_tmo_dst;
                 else if (!avm_waitrequest) w_state_nxt = S_WAIT_ID;
      S_WAIT_ID: if (avm_readdatavalid) w_state_nxt = S_REQ_TS;
                 else if (w_tmo) w_state_nxt = w_tmo_dst;
      S_REQ_TS:  if (w_tmo) w_state_nxt = w_tmo_dst;
                 else if (!avm_waitrequest) w_state_nxt = S_WAIT_TS;
      S_WAIT_TS: if (avm_readdatavalid) w_state_nxt = S_CHECK;
                 else if (w_tmo) w_state_nxt = w_tmo_dst;
      S_CHECK:   w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    avm_read    = 1'b0;
    avm_address = 1'b0;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;
    case (r_state)
      S_REQ_ID:  avm_read = 1'b1;
      S_REQ_TS:  begin avm_read = 1'b1; avm_address = 1'b1; end
      S_WAIT_TS: avm_address = 1'b1;
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tcnt  <= '0;
      r_retry <= '0;
      r_pass  <= 1'b0;
      r_err   <= 2'd0;
      r_id    <= '0;
      r_ts    <= '0;
    end else begin
      if (w_tcnt_clr)   r_tcnt <= '0;
      else if (w_in_rd) r_tcnt <= r_tcnt + 16'd1;
      if (r_state == S_IDLE && start) begin
        r_retry <= '0;
        r_pass  <= 1'b0;
        r_err   <= 2'd0;
      end
      if (w_tmo && w_retry_ok) r_retry <= r_retry + 4'd1;
      if (w_tmo && !w_retry_ok) begin
        r_err  <= 2'd3;
        r_pass <= 1'b0;
      end
      if (r_state == S_WAIT_ID && avm_readdatavalid) r_id <= avm_readdata;
      if (r_state == S_WAIT_TS && avm_readdatavalid) r_ts <= avm_readdata;
      if (r_state == S_CHECK) begin
        r_err  <= w_code;
        r_pass <= (w_code == 2'd0);
      end
    end
  end

  assign pass          = r_pass;
  assign error_code    = r_err;
  assign id_out        = r_id;
  assign timestamp_out = r_ts;

endmodule
